seq_adder_unit: RTL

//  Parametrised multi-cycle adder/subtractor, successor to the 1-bit full adder cell.

---
 rtl/seq_adder_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/seq_adder_unit.sv
// seq_adder_unit: multi-cycle unsigned adder/subtractor, SLICE bits per clock through a ripple slice.
// Latency: WIDTH/SLICE cycles from the accept edge to the done edge. One operation in flight at a time.
// Backpressure: start is accepted only while busy==0 and is ignored while busy==1. done is a single-cycle pulse.
//
// Ports:
//   clk, rst_n      rising-edge clock; asynchronous active-low reset
//   start           request; accepted when idle (including the done cycle)
//   sub             0: a+b+cin, 1: a-b (cin ignored)
//   a, b, cin       operands, sampled on accept
//   busy            high while a computation is in progress
//   done            one-cycle pulse; sum/cout (and ovf) updated on the same edge
//   sum, cout       result and final carry; in sub mode cout=1 means no borrow
//   ovf             signed overflow, present only when SEQ_ADDER_OVF_EN is defined
module seq_adder_unit #(
   parameter int WIDTH = 8,
   parameter int SLICE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SEQ_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NSL = WIDTH / SLICE;
   localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(NSL - 1);

   generate
      if ((SLICE < 1) || (WIDTH < 2) || ((WIDTH % SLICE) != 0)) begin : g_bad_param
         $error("seq_adder_unit: WIDTH must be >= 2 and a multiple of SLICE");
      end
   endgenerate

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] ra, rb, acc, acc_nxt;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             accept, last;
   logic [SLICE:0]   slice_res;

   // Slice ripple: low SLICE bits of the shifting operands plus the registered carry.
   always_comb begin
      slice_res = {1'b0, ra[SLICE-1:0]} + {1'b0, rb[SLICE-1:0]} + {{SLICE{1'b0}}, carry};
      // New slice enters at the top; after NSL slices the first slice sits at bit 0.
      acc_nxt   = WIDTH'({slice_res[SLICE-1:0], acc} >> SLICE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (cnt == CNT_LAST) begin
               last      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ra    <= '0;
         rb    <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef SEQ_ADDER_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (accept) begin
            ra    <= a;
            // Subtraction as a + ~b + 1.
            rb    <= sub ? ~b : b;
            carry <= sub | cin;
            acc   <= '0;
            cnt   <= '0;
         end else if (state == RUN) begin
            ra    <= ra >> SLICE;
            rb    <= rb >> SLICE;
            acc   <= acc_nxt;
            carry <= slice_res[SLICE];
            cnt   <= cnt + 1'b1;
            if (last) begin
               sum  <= acc_nxt;
               cout <= slice_res[SLICE];
               done <= 1'b1;
`ifdef SEQ_ADDER_OVF_EN
               // On the last slice ra/rb hold the operand MSBs, so carry into the MSB
               // is recovered as a ^ b ^ s at the top bit of the slice.
               ovf  <= (ra[SLICE-1] ^ rb[SLICE-1] ^ slice_res[SLICE-1]) ^ slice_res[SLICE];
`endif
            end
         end
      end
   end

endmodule
